multi_channel_fifo: RTL and testbench
=====================================

// Module: multi_channel_fifo
// PURPOSE
//   Synthesizable N-channel FIFO bank; successor to the two-channel behavioural queue model.
//   Per-channel push/pop, registered head output, full/empty/count status; depth and width parametrised.
//   Sits between upstream producers and downstream consumers; same head-data semantics as the model, so the model serves as scoreboard.
// PARAMETERS
//   D_WIDTH  6  data word width per channel
//   NUM_CH   2  number of independent channels (>=1)
//   DEPTH    4  entries per channel; power of two, >=2
// PORTS
//   clk          in   1                       sole clock, rising edge
//   rst          in   1                       asynchronous, active-low reset
//   up_data      in   NUM_CH*D_WIDTH          push data; channel c at [c*D_WIDTH +: D_WIDTH]
//   push         in   NUM_CH                  push request per channel
//   pop          in   NUM_CH                  pop request per channel
//   down_data    out  NUM_CH*D_WIDTH          registered head word per channel
//   full         out  NUM_CH                  count == DEPTH
//   empty        out  NUM_CH                  count == 0
//   count        out  NUM_CH*$clog2(DEPTH+1)  occupancy per channel
//   ovf_err      out  NUM_CH                  [MCFIFO_ERR_FLAGS_EN only] sticky overflow
//   udf_err      out  NUM_CH                  [MCFIFO_ERR_FLAGS_EN only] sticky underflow
//   err_clr      in   1                       [MCFIFO_ERR_FLAGS_EN only] clears both sticky flags
// BEHAVIOUR
//   - Reset (rst=0, async assert, sync-to-clk deassert by upstream): pointers, count, down_data = 0; empty=1, full=0.
//   - Channels fully independent; all rules below apply per channel, same clock edge.
//   - Pop accepted iff count>0 before the edge; push accepted iff count<DEPTH, or count==DEPTH with accepted pop.
//   - Push+pop on empty: pop ignored, push stored, count 0->1.
//   - Push+pop on full: both accepted, count stays DEPTH, oldest word leaves, new word at tail.
//   - Rejected push: data dropped, state unchanged. Rejected pop: no effect.
//   - down_data: after each edge equals head of queue as updated on that edge (1-cycle latency push->down_data
//     on empty channel); 0 whenever channel empty after the edge. Registered, no combinational path from inputs.
//   - Pointers: $clog2(DEPTH) bits, natural wrap at DEPTH; count separate, never exceeds DEPTH.
//   - full/empty/count registered, consistent with down_data on the same cycle.
//   - Reset asserted mid-operation: all contents discarded immediately, outputs to reset values.
// CONFIGURATION
//   MCFIFO_ERR_FLAGS_EN defined: ovf_err[c] set on rejected push, udf_err[c] set on rejected pop; sticky until
//     err_clr=1 at an edge (clear wins over set same edge); reset value 0. Storage behaviour identical.
//   Undefined: ovf_err, udf_err, err_clr ports absent; rejected requests silently dropped.
// STRUCTURE
//   mcfifo_pkg: function ptr_w(DEPTH)=$clog2(DEPTH), cnt_w(DEPTH)=$clog2(DEPTH+1); push/pop action enum
//     {NONE, PUSH, POP, BOTH} used by channel next-state logic.
//   Sub-module mcfifo_channel: one channel (storage array, rd/wr pointers, count, head register, optional flags);
//     top instantiates NUM_CH copies in a generate loop and packs/unpacks the flattened buses.
// TESTING
//   T1 reset: rst=0 mid-traffic -> empty=all 1, count=0, down_data=0 without waiting for clk edge.
//   T2 fill/drain, D_WIDTH=6 DEPTH=4: push 0x01..0x04 ch0 -> full[0]=1, count=4; 5th push 0x05 dropped;
//      pop x4 -> down_data sequence 0x02,0x03,0x04,0 and empty[0]=1.
//   T3 simultaneous: ch0 empty push 0x2A+pop -> count=1, down_data=0x2A; ch0 full push 0x11+pop -> count=4,
//      tail=0x11, head advances by one.
//   T4 independence, NUM_CH=4: push ch1 only, pop ch3 (empty) -> ch1 count=1, ch0/2/3 unchanged, no cross-talk.
//   T5 wrap: 3*DEPTH interleaved push/pop on one channel with count=2 steady -> order preserved through pointer wrap.
//   T6 MCFIFO_ERR_FLAGS_EN: push on full -> ovf_err=1 holds; pop on empty -> udf_err=1; err_clr=1 -> both 0 next cycle.
//   Scoreboard: behavioural queue model driven with same stimulus, compare down_data/count every cycle
//     (except model push-then-pop-on-empty case, excluded from comparison).

Source files
------------

// File: rtl/mcfifo_pkg.sv
// mcfifo_pkg: shared widths and the per-channel push/pop action decode for the
// multi-channel FIFO bank.
package mcfifo_pkg;

  // Accepted-request combination seen by one channel on one clock edge.
  typedef enum logic [1:0] {
    ActNone,
    ActPush,
    ActPop,
    ActBoth
  } action_e;

  // Read/write pointer width; pointers wrap naturally at DEPTH (power of two).
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // Occupancy counter width; must be able to hold DEPTH itself.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Fold the accepted push/pop qualifiers into one action.
  function automatic action_e to_action(input logic push_ok, input logic pop_ok);
    action_e act;
    case ({push_ok, pop_ok})
      2'b10:   act = ActPush;
      2'b01:   act = ActPop;
      2'b11:   act = ActBoth;
      default: act = ActNone;
    endcase
    return act;
  endfunction

endpackage

// File: rtl/multi_channel_fifo_if.sv
// multi_channel_fifo_if: flattened per-channel push/pop/status bus of the FIFO bank.
// Optional sticky error flags are present only when MCFIFO_ERR_FLAGS_EN is defined.
interface multi_channel_fifo_if
  import mcfifo_pkg::*;
#(
  parameter int unsigned D_WIDTH = 6,
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned DEPTH   = 4
);

  logic [NUM_CH*D_WIDTH-1:0]        up_data;
  logic [NUM_CH-1:0]                push;
  logic [NUM_CH-1:0]                pop;
  logic [NUM_CH*D_WIDTH-1:0]        down_data;
  logic [NUM_CH-1:0]                full;
  logic [NUM_CH-1:0]                empty;
  logic [NUM_CH*cnt_w(DEPTH)-1:0]   count;
`ifdef MCFIFO_ERR_FLAGS_EN
  logic [NUM_CH-1:0]                ovf_err;
  logic [NUM_CH-1:0]                udf_err;
  logic                             err_clr;

  // Producer/consumer side.
  modport master (
    output up_data, push, pop, err_clr,
    input  down_data, full, empty, count, ovf_err, udf_err
  );

  // FIFO bank side.
  modport slave (
    input  up_data, push, pop, err_clr,
    output down_data, full, empty, count, ovf_err, udf_err
  );
`else
  // Producer/consumer side.
  modport master (
    output up_data, push, pop,
    input  down_data, full, empty, count
  );

  // FIFO bank side.
  modport slave (
    input  up_data, push, pop,
    output down_data, full, empty, count
  );
`endif

endinterface

// File: rtl/mcfifo_channel.sv
// mcfifo_channel: one FIFO channel with storage array, wrapping rd/wr pointers, separate
// occupancy count and a registered head word. MCFIFO_ERR_FLAGS_EN adds sticky
// overflow/underflow flags.
module mcfifo_channel
  import mcfifo_pkg::*;
#(
  parameter int unsigned D_WIDTH = 6,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_push,
  input  logic                      i_pop,
  input  logic [D_WIDTH-1:0]        i_data,
`ifdef MCFIFO_ERR_FLAGS_EN
  input  logic                      i_err_clr,
  output logic                      o_ovf_err,
  output logic                      o_udf_err,
`endif
  output logic [D_WIDTH-1:0]        o_data,
  output logic                      o_full,
  output logic                      o_empty,
  output logic [cnt_w(DEPTH)-1:0]   o_count
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] CntFull = CW'(DEPTH);
  localparam logic [CW-1:0] CntOne  = CW'(1);

  logic [D_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]      r_rd_ptr;
  logic [PW-1:0]      r_wr_ptr;
  logic [CW-1:0]      r_count;
  logic [D_WIDTH-1:0] r_head;

  logic               w_pop_ok;
  logic               w_push_ok;
  action_e            w_act;
  logic [PW-1:0]      w_rd_next;
  logic [CW-1:0]      w_count_d;
  logic [D_WIDTH-1:0] w_head_d;

  // Accept/reject decode and next head/count; the head must reflect the queue after the edge.
  always_comb begin
    w_pop_ok  = i_pop && (r_count != '0);
    // A push into a full channel is only accepted when a pop frees a slot on the same edge.
    w_push_ok = i_push && ((r_count != CntFull) || w_pop_ok);
    w_act     = to_action(w_push_ok, w_pop_ok);
    w_rd_next = r_rd_ptr + PW'(1);
    w_count_d = r_count;
    w_head_d  = r_head;
    case (w_act)
      ActPush: begin
        w_count_d = r_count + CntOne;
        if (r_count == '0) begin
          w_head_d = i_data;
        end
      end
      ActPop: begin
        w_count_d = r_count - CntOne;
        w_head_d  = (r_count == CntOne) ? '0 : r_mem[w_rd_next];
      end
      ActBoth: begin
        // With a single entry, the incoming word becomes the only (head) entry.
        w_head_d = (r_count == CntOne) ? i_data : r_mem[w_rd_next];
      end
      default: ;
    endcase
  end

  // Storage write; contents need no reset since pointers and count define validity.
  always_ff @(posedge clk) begin
    if (rst && w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer, count and head-word state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else begin
      if (w_pop_ok) begin
        r_rd_ptr <= w_rd_next;
      end
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      r_count <= w_count_d;
      r_head  <= w_head_d;
    end
  end

`ifdef MCFIFO_ERR_FLAGS_EN
  logic r_ovf_err;
  logic r_udf_err;

  // Sticky error flags; clear takes priority over a same-edge set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf_err <= 1'b0;
      r_udf_err <= 1'b0;
    end else if (i_err_clr) begin
      r_ovf_err <= 1'b0;
      r_udf_err <= 1'b0;
    end else begin
      if (i_push && !w_push_ok) begin
        r_ovf_err <= 1'b1;
      end
      if (i_pop && !w_pop_ok) begin
        r_udf_err <= 1'b1;
      end
    end
  end

  assign o_ovf_err = r_ovf_err;
  assign o_udf_err = r_udf_err;
`endif

  assign o_data  = r_head;
  assign o_count = r_count;
  assign o_full  = (r_count == CntFull);
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/multi_channel_fifo.sv
// multi_channel_fifo: NUM_CH independent FIFO channels sharing one clock and reset.
// Define MCFIFO_ERR_FLAGS_EN to add sticky ovf_err/udf_err flags and err_clr.
module multi_channel_fifo
  import mcfifo_pkg::*;
#(
  parameter int unsigned D_WIDTH = 6,
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                clk,
  input  logic                rst,
  multi_channel_fifo_if.slave bus
);

  localparam int unsigned CW = cnt_w(DEPTH);

  // One channel per lane, unpacked from and packed back into the flattened buses.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    mcfifo_channel #(
      .D_WIDTH(D_WIDTH),
      .DEPTH  (DEPTH)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .i_push   (bus.push[c]),
      .i_pop    (bus.pop[c]),
      .i_data   (bus.up_data[c*D_WIDTH +: D_WIDTH]),
`ifdef MCFIFO_ERR_FLAGS_EN
      .i_err_clr(bus.err_clr),
      .o_ovf_err(bus.ovf_err[c]),
      .o_udf_err(bus.udf_err[c]),
`endif
      .o_data   (bus.down_data[c*D_WIDTH +: D_WIDTH]),
      .o_full   (bus.full[c]),
      .o_empty  (bus.empty[c]),
      .o_count  (bus.count[c*CW +: CW])
    );
  end

endmodule

// File: tb/tb_multi_channel_fifo.sv
// tb_multi_channel_fifo: directed checks of the FIFO bank with D_WIDTH=6, NUM_CH=4, DEPTH=4.
// Sticky-flag checks are included when MCFIFO_ERR_FLAGS_EN is defined.
module tb_multi_channel_fifo;

  localparam int unsigned DW = 6;
  localparam int unsigned NC = 4;
  localparam int unsigned DP = 4;
  localparam int unsigned CW = 3;

  logic clk;
  logic rst;
  int   n_err = 0;
  int   n_chk = 0;

  multi_channel_fifo_if #(.D_WIDTH(DW), .NUM_CH(NC), .DEPTH(DP)) bus ();

  multi_channel_fifo #(
    .D_WIDTH(DW),
    .NUM_CH (NC),
    .DEPTH  (DP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] cnt(input int c);
    return 32'(bus.count[c*CW +: CW]);
  endfunction

  function automatic logic [31:0] dd(input int c);
    return 32'(bus.down_data[c*DW +: DW]);
  endfunction

  task automatic set_data(input int c, input logic [DW-1:0] v);
    bus.up_data[c*DW +: DW] = v;
  endtask

  task automatic push1(input int c, input logic [DW-1:0] v);
    set_data(c, v);
    bus.push[c] = 1'b1;
    step();
    bus.push[c] = 1'b0;
  endtask

  task automatic pop1(input int c);
    bus.pop[c] = 1'b1;
    step();
    bus.pop[c] = 1'b0;
  endtask

  initial begin
    rst          = 1'b0;
    bus.push     = '0;
    bus.pop      = '0;
    bus.up_data  = '0;
`ifdef MCFIFO_ERR_FLAGS_EN
    bus.err_clr  = 1'b0;
`endif
    #1;
    check("rst_empty", 32'(bus.empty), 32'hF);
    check("rst_full", 32'(bus.full), 32'h0);
    check("rst_count", 32'(bus.count), 32'h0);
    check("rst_ddata", 32'(bus.down_data), 32'h0);
    step();
    step();
    rst = 1'b1;
    step();

    // T2 fill/drain on ch0
    push1(0, 6'h01);
    check("t2_cnt1", cnt(0), 1);
    check("t2_dd1", dd(0), 6'h01);
    push1(0, 6'h02);
    push1(0, 6'h03);
    push1(0, 6'h04);
    check("t2_full", 32'(bus.full), 32'h1);
    check("t2_cnt4", cnt(0), 4);
    check("t2_dd_full", dd(0), 6'h01);
    push1(0, 6'h05);
    check("t2_ovf_cnt", cnt(0), 4);
    check("t2_ovf_dd", dd(0), 6'h01);
    pop1(0);
    check("t2_pop1", dd(0), 6'h02);
    check("t2_pop1_cnt", cnt(0), 3);
    pop1(0);
    check("t2_pop2", dd(0), 6'h03);
    pop1(0);
    check("t2_pop3", dd(0), 6'h04);
    pop1(0);
    check("t2_pop4", dd(0), 6'h00);
    check("t2_empty", 32'(bus.empty), 32'hF);
    pop1(0);
    check("t2_udf_cnt", cnt(0), 0);

    // T3 simultaneous push+pop on empty, then on full
    set_data(0, 6'h2A);
    bus.push[0] = 1'b1;
    bus.pop[0]  = 1'b1;
    step();
    bus.push[0] = 1'b0;
    bus.pop[0]  = 1'b0;
    check("t3_empty_cnt", cnt(0), 1);
    check("t3_empty_dd", dd(0), 6'h2A);
    push1(0, 6'h12);
    push1(0, 6'h13);
    push1(0, 6'h14);
    check("t3_full_pre", cnt(0), 4);
    set_data(0, 6'h11);
    bus.push[0] = 1'b1;
    bus.pop[0]  = 1'b1;
    step();
    bus.push[0] = 1'b0;
    bus.pop[0]  = 1'b0;
    check("t3_full_cnt", cnt(0), 4);
    check("t3_full_dd", dd(0), 6'h12);
    check("t3_full_flag", 32'(bus.full), 32'h1);
    pop1(0);
    check("t3_drain1", dd(0), 6'h13);
    pop1(0);
    check("t3_drain2", dd(0), 6'h14);
    pop1(0);
    check("t3_tail", dd(0), 6'h11);
    pop1(0);
    check("t3_drain4", dd(0), 6'h00);

    // T4 independence: push ch1, pop empty ch3, other lanes carry stray data
    set_data(0, 6'h3F);
    set_data(2, 6'h15);
    set_data(3, 6'h2E);
    set_data(1, 6'h33);
    bus.push[1] = 1'b1;
    bus.pop[3]  = 1'b1;
    step();
    bus.push = '0;
    bus.pop  = '0;
    check("t4_cnt1", cnt(1), 1);
    check("t4_dd1", dd(1), 6'h33);
    check("t4_cnt0", cnt(0), 0);
    check("t4_cnt2", cnt(2), 0);
    check("t4_cnt3", cnt(3), 0);
    check("t4_empty", 32'(bus.empty), 32'hD);
    check("t4_dd_other", 32'(bus.down_data) & 32'hFFFF_F03F, 32'h0);
    pop1(1);
    check("t4_clear", 32'(bus.empty), 32'hF);

    // T5 wrap on ch2: steady count 2 through 3*DEPTH push+pop cycles
    push1(2, 6'd1);
    push1(2, 6'd2);
    check("t5_pre_cnt", cnt(2), 2);
    check("t5_pre_dd", dd(2), 6'd1);
    for (int k = 0; k < 3 * DP; k++) begin
      set_data(2, 6'(k + 3));
      bus.push[2] = 1'b1;
      bus.pop[2]  = 1'b1;
      step();
      check($sformatf("t5_dd_%0d", k), dd(2), 32'(k + 2));
      check($sformatf("t5_cnt_%0d", k), cnt(2), 2);
    end
    bus.push[2] = 1'b0;
    bus.pop[2]  = 1'b0;
    pop1(2);
    check("t5_last", dd(2), 6'd14);
    pop1(2);
    check("t5_end", dd(2), 6'd0);
    check("t5_empty", 32'(bus.empty), 32'hF);

    // T1 reset mid-traffic, observed before any clock edge
    push1(0, 6'h07);
    set_data(1, 6'h08);
    bus.push[1] = 1'b1;
    step();
    check("t1_pre_cnt0", cnt(0), 1);
    rst = 1'b0;
    #1;
    check("t1_empty", 32'(bus.empty), 32'hF);
    check("t1_count", 32'(bus.count), 32'h0);
    check("t1_ddata", 32'(bus.down_data), 32'h0);
    bus.push = '0;
    step();
    step();
    rst = 1'b1;
    step();
    check("t1_post_empty", 32'(bus.empty), 32'hF);
    push1(0, 6'h15);
    check("t1_post_dd", dd(0), 6'h15);
    check("t1_post_cnt", cnt(0), 1);
    pop1(0);

`ifdef MCFIFO_ERR_FLAGS_EN
    // T6 sticky flags
    check("t6_rst_flags", 32'({bus.ovf_err, bus.udf_err}), 32'h0);
    pop1(0);
    check("t6_udf", 32'(bus.udf_err), 32'h1);
    push1(0, 6'h01);
    push1(0, 6'h02);
    push1(0, 6'h03);
    push1(0, 6'h04);
    check("t6_no_ovf_yet", 32'(bus.ovf_err), 32'h0);
    push1(0, 6'h05);
    check("t6_ovf", 32'(bus.ovf_err), 32'h1);
    step();
    check("t6_ovf_hold", 32'(bus.ovf_err), 32'h1);
    check("t6_udf_hold", 32'(bus.udf_err), 32'h1);
    bus.err_clr = 1'b1;
    bus.pop[3]  = 1'b1;
    step();
    bus.err_clr = 1'b0;
    bus.pop[3]  = 1'b0;
    check("t6_clr_ovf", 32'(bus.ovf_err), 32'h0);
    check("t6_clr_udf", 32'(bus.udf_err), 32'h0);
    check("t6_store_kept", cnt(0), 4);
    check("t6_store_dd", dd(0), 6'h01);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
